// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, opcode constants, issued-op record and RV32 decode.
package alu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_ZERO, ALU_MUL
  } alu_ctrl_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MUL     = 7'b0000001;
  typedef struct packed {
    alu_ctrl_e        ctrl;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic             branch;
    logic             illegal;
  } issue_op_t;
  localparam issue_op_t OP_RESET = '{ALU_ZERO, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0};
  function automatic alu_ctrl_e f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic issue_op_t decode(input logic [31:0] i, input logic [XLEN-1:0] rs1,
                                       input logic [XLEN-1:0] rs2);
    issue_op_t d;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic shift;
    logic ok;
    opc = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    shift = f3 == 3'b001 || f3 == 3'b101;
    d = OP_RESET;
    d.rd_addr = i[11:7];
    ok = 1'b0;
    case (opc)
      OPC_OP: begin
        ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) ||
             (f7 == F7_MUL && f3 == 3'b000);
        d.ctrl = f7 == F7_MUL ? ALU_MUL : f7 == F7_ALT ? (f3 == 3'b000 ? ALU_SUB : ALU_SRA) : f3_ctrl(f3);
        d.op_a = rs1;
        d.op_b = rs2;
      end
      OPC_OP_IMM: begin
        ok = !shift || f7 == F7_BASE || (f3 == 3'b101 && f7 == F7_ALT);
        d.ctrl = (f3 == 3'b101 && f7 == F7_ALT) ? ALU_SRA : f3_ctrl(f3);
        d.op_a = rs1;
        // shifts carry only the shamt so op_b is the real shift amount
        d.op_b = shift ? XLEN'(i[24:20]) : {{(XLEN-12){i[31]}}, i[31:20]};
      end
      OPC_LUI: begin
        ok = 1'b1;
        d.ctrl = ALU_ADD;
        d.op_b = XLEN'({i[31:12], 12'b0});
      end
      OPC_BRANCH: begin
        ok = f3[2:1] == 2'b00;
        d.ctrl = ALU_SUB;
        d.op_a = rs1;
        d.op_b = rs2;
        d.branch = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) d = '{ALU_ZERO, '0, '0, i[11:7], 1'b0, 1'b0, 1'b1};
    else d.rd_we = opc != OPC_BRANCH && i[11:7] != 5'd0;
    return d;
  endfunction
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: main output register plus one skid slot; in_ready is registered.
module alu_skid_buffer #(
  parameter type T = logic,
  parameter T RST_VAL = T'(0)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  logic skid_valid;
  T     skid;
  logic accept, drain;
  assign in_ready = !skid_valid;
  assign accept = in_valid && !skid_valid;
  assign drain = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_data <= RST_VAL;
      skid <= RST_VAL;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_data <= skid;
        out_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) out_data <= in_data;
      end
    end else if (accept) begin
      skid <= in_data;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes RV32 ALU/branch ops and issues one registered op per cycle to the ALU.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_alu_ctrl,
  output logic [DATA_WIDTH-1:0] out_op_a,
  output logic [DATA_WIDTH-1:0] out_op_b,
  output logic [4:0]            out_rd_addr,
  output logic                  out_rd_we,
  output logic                  out_is_branch,
  output logic                  out_illegal
);
  issue_op_t dec, cur;
  assign dec = decode(in_instr, in_rs1_data, in_rs2_data);
  alu_skid_buffer #(.T(issue_op_t), .RST_VAL(OP_RESET)) u_buf (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(cur)
  );
  assign out_alu_ctrl = cur.ctrl;
  assign out_op_a = cur.op_a;
  assign out_op_b = cur.op_b;
  assign out_rd_addr = cur.rd_addr;
  assign out_rd_we = cur.rd_we;
  assign out_is_branch = cur.branch;
  assign out_illegal = cur.illegal;
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed vector table plus stall, flush and async-reset sequences.
module tb_alu_op_issue;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_rd_we, out_is_branch, out_illegal;
  logic [31:0] in_instr = '0, in_rs1_data = '0, in_rs2_data = '0, out_op_a, out_op_b;
  logic [3:0] out_alu_ctrl;
  logic [4:0] out_rd_addr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_op_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd_addr(out_rd_addr),
    .out_rd_we(out_rd_we), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );
  typedef struct {
    logic [31:0] instr, rs1, rs2;
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        we, br, ill;
  } vec_t;
  vec_t v [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
    in_instr = instr;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask
  initial begin
    v = '{
      '{32'h002081B3, 32'd5,        32'd7, 4'h0, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0, 1'b0},
      '{32'h40315093, 32'h80000000, 32'd9, 4'h7, 32'h80000000, 32'd3,        5'd1, 1'b1, 1'b0, 1'b0},
      '{32'h00208463, 32'd9,        32'd9, 4'h1, 32'd9,        32'd9,        5'd8, 1'b0, 1'b1, 1'b0},
      '{32'h022081B3, 32'd6,        32'd7, 4'hb, 32'd6,        32'd7,        5'd3, 1'b1, 1'b0, 1'b0},
      '{32'h0000007F, 32'd4,        32'd4, 4'ha, 32'd0,        32'd0,        5'd0, 1'b0, 1'b0, 1'b1},
      '{32'h123452B7, 32'd1,        32'd2, 4'h0, 32'd0,        32'h12345000, 5'd5, 1'b1, 1'b0, 1'b0},
      '{32'hFFF08013, 32'h10,       32'd2, 4'h0, 32'h10,       32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b0},
      '{32'h40208233, 32'd10,       32'd3, 4'h1, 32'd10,       32'd3,        5'd4, 1'b1, 1'b0, 1'b0},
      '{32'h4020D233, 32'd10,       32'd3, 4'h7, 32'd10,       32'd3,        5'd4, 1'b1, 1'b0, 1'b0},
      '{32'h40209033, 32'd10,       32'd3, 4'ha, 32'd0,        32'd0,        5'd0, 1'b0, 1'b0, 1'b1},
      '{32'h00409113, 32'h55,       32'd3, 4'h2, 32'h55,       32'd4,        5'd2, 1'b1, 1'b0, 1'b0},
      '{32'h0040D113, 32'h55,       32'd3, 4'h6, 32'h55,       32'd4,        5'd2, 1'b1, 1'b0, 1'b0},
      '{32'h02009013, 32'h55,       32'd3, 4'ha, 32'd0,        32'd0,        5'd0, 1'b0, 1'b0, 1'b1},
      '{32'h00209463, 32'd1,        32'd2, 4'h1, 32'd1,        32'd2,        5'd8, 1'b0, 1'b1, 1'b0},
      '{32'h0020A063, 32'd1,        32'd2, 4'ha, 32'd0,        32'd0,        5'd0, 1'b0, 1'b0, 1'b1},
      '{32'h0020B2B3, 32'd1,        32'd2, 4'h4, 32'd1,        32'd2,        5'd5, 1'b1, 1'b0, 1'b0},
      '{32'h8000F293, 32'hABCD,     32'd2, 4'h9, 32'hABCD,     32'hFFFFF800, 5'd5, 1'b1, 1'b0, 1'b0}
    };
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst ctrl", 32'(out_alu_ctrl), 32'ha);
    chk("rst op_a", out_op_a, 32'd0);
    chk("rst op_b", out_op_b, 32'd0);
    rst = 1'b0;
    step();
    for (int k = 0; k < 17; k++) begin
      drive(v[k].instr, v[k].rs1, v[k].rs2);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d ctrl", k), 32'(out_alu_ctrl), 32'(v[k].ctrl));
      chk($sformatf("v%0d op_a", k), out_op_a, v[k].a);
      chk($sformatf("v%0d op_b", k), out_op_b, v[k].b);
      chk($sformatf("v%0d rd", k), 32'(out_rd_addr), 32'(v[k].rd));
      chk($sformatf("v%0d we", k), 32'(out_rd_we), 32'(v[k].we));
      chk($sformatf("v%0d br", k), 32'(out_is_branch), 32'(v[k].br));
      chk($sformatf("v%0d ill", k), 32'(out_illegal), 32'(v[k].ill));
      if (k == 1) chk("srai alu result", 32'($signed(out_op_a) >>> out_op_b[4:0]), 32'hF0000000);
    end
    step();
    chk("idle out_valid", 32'(out_valid), 32'd0);
    // stall: three back-to-back ops against a blocked consumer
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd11, 32'd1);
    in_valid = 1'b1;
    step();
    chk("stall1 valid", 32'(out_valid), 32'd1);
    chk("stall1 a", out_op_a, 32'd11);
    chk("stall1 in_ready", 32'(in_ready), 32'd1);
    drive(32'h002081B3, 32'd22, 32'd1);
    step();
    chk("stall2 a", out_op_a, 32'd11);
    chk("stall2 in_ready", 32'(in_ready), 32'd0);
    drive(32'h002081B3, 32'd33, 32'd1);
    step();
    chk("stall3 a", out_op_a, 32'd11);
    chk("stall3 in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("rel1 a", out_op_a, 32'd22);
    chk("rel1 in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("rel2 a", out_op_a, 32'd33);
    chk("rel2 valid", 32'(out_valid), 32'd1);
    step();
    chk("rel3 valid", 32'(out_valid), 32'd0);
    // flush with skid full and a new op offered
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd44, 32'd1);
    in_valid = 1'b1;
    step();
    drive(32'h002081B3, 32'd55, 32'd1);
    step();
    chk("pre-flush in_ready", 32'(in_ready), 32'd0);
    drive(32'h002081B3, 32'd66, 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush valid", 32'(out_valid), 32'd0);
    chk("flush in_ready", 32'(in_ready), 32'd1);
    step();
    chk("post-flush valid", 32'(out_valid), 32'd0);
    // async reset mid-stall, asserted between clock edges
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd77, 32'd1);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("prerst in_ready", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("arst valid", 32'(out_valid), 32'd0);
    chk("arst ctrl", 32'(out_alu_ctrl), 32'ha);
    chk("arst in_ready", 32'(in_ready), 32'd1);
    chk("arst op_a", out_op_a, 32'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("post-rst valid", 32'(out_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
